// File: rtl/ingress_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ingress_arbiter
// Purpose  : Shares the conflict-detection pipeline input among NUM_REQUESTERS
//            single-beat AXI-Stream sources. Round-robin arbitration with a
//            bounded burst allowance; the winning beat is held in a registered
//            output slice that supports a load and a drain in the same cycle.
// Ports    : clk, rst (async, active-high)
//            s_axis_*  : per-source valid/ready and packed data
//                        (programID 64b, read/write dependency vectors)
//            pause     : blocks new grants, the held beat still drains
//            m_axis_*  : registered output beat plus source index
//            grants_total, contention_cycles : saturating statistics
// Revision : 1.0 - initial release
// ============================================================================
module ingress_arbiter #(
  parameter int NUM_REQUESTERS   = 4,
  parameter int MAX_DEPENDENCIES = 256,
  parameter int MAX_BURST        = 4,
  localparam int SRC_W           = $clog2(NUM_REQUESTERS)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_REQUESTERS-1:0]                s_axis_tvalid,
  output logic [NUM_REQUESTERS-1:0]                s_axis_tready,
  input  logic [NUM_REQUESTERS*64-1:0]             s_axis_tdata_owner_programID,
  input  logic [NUM_REQUESTERS*MAX_DEPENDENCIES-1:0] s_axis_tdata_read_dependencies,
  input  logic [NUM_REQUESTERS*MAX_DEPENDENCIES-1:0] s_axis_tdata_write_dependencies,
  input  logic                                     pause,
  output logic                                     m_axis_tvalid,
  input  logic                                     m_axis_tready,
  output logic [63:0]                              m_axis_tdata_owner_programID,
  output logic [MAX_DEPENDENCIES-1:0]              m_axis_tdata_read_dependencies,
  output logic [MAX_DEPENDENCIES-1:0]              m_axis_tdata_write_dependencies,
  output logic [SRC_W-1:0]                         m_axis_tsource,
  output logic [31:0]                              grants_total,
  output logic [31:0]                              contention_cycles
);

  localparam int                NUM_SRC     = NUM_REQUESTERS;
  localparam int                MD          = MAX_DEPENDENCIES;
  localparam int                BC_W        = $clog2(MAX_BURST + 1);
  localparam logic [BC_W-1:0]   BURST_LIMIT = BC_W'(MAX_BURST);
  localparam logic [SRC_W-1:0]  LAST_SRC    = SRC_W'(NUM_REQUESTERS - 1);

  // Registered state
  logic                 tvalid_q,   tvalid_d;
  logic [63:0]          prog_q,     prog_d;
  logic [MD-1:0]        rd_q,       rd_d;
  logic [MD-1:0]        wr_q,       wr_d;
  logic [SRC_W-1:0]     tsource_q,  tsource_d;
  logic [SRC_W-1:0]     last_grant_q, last_grant_d;
  logic [BC_W-1:0]      burst_cnt_q,  burst_cnt_d;
  logic [31:0]          grants_q,   grants_d;
  logic [31:0]          contend_q,  contend_d;

  // Arbitration wires
  logic                 load_en;
  logic                 any_valid;
  logic                 multi_valid;
  logic                 burst_cont;
  logic                 handshake;
  logic                 rr_found;
  logic [SRC_W-1:0]     rr_idx;
  logic [SRC_W-1:0]     grant;
  int                   scan;
  logic [63:0]          sel_prog;
  logic [MD-1:0]        sel_rd;
  logic [MD-1:0]        sel_wr;

  // rst gates the load enable so no source sees ready while reset is held.
  assign load_en     = !rst && !pause && (!tvalid_q || m_axis_tready);
  assign any_valid   = |s_axis_tvalid;
  // Clearing the lowest set bit leaves a non-zero value iff >=2 bits are set.
  assign multi_valid = (s_axis_tvalid & (s_axis_tvalid - NUM_SRC'(1))) != '0;
  assign handshake   = load_en && any_valid;

  // A zero burst count only exists straight after reset, so it doubles as
  // the "no prior grant" marker.
  assign burst_cont  = (burst_cnt_q != '0) && (burst_cnt_q < BURST_LIMIT) &&
                       s_axis_tvalid[last_grant_q];

  // Round-robin scan starting after last_grant. The final step (k == N)
  // revisits last_grant itself, which is how a sole valid source keeps
  // winning after its burst allowance is spent.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    scan     = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      scan = (int'(last_grant_q) + k) % NUM_SRC;
      if (!rr_found && s_axis_tvalid[scan]) begin
        rr_found = 1'b1;
        rr_idx   = SRC_W'(scan);
      end
    end
  end

  assign grant = burst_cont ? last_grant_q : rr_idx;

  // Ready and data select for the granted source
  always_comb begin
    s_axis_tready = '0;
    sel_prog      = '0;
    sel_rd        = '0;
    sel_wr        = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant == SRC_W'(i)) begin
        s_axis_tready[i] = handshake;
        sel_prog         = s_axis_tdata_owner_programID[i*64 +: 64];
        sel_rd           = s_axis_tdata_read_dependencies[i*MD +: MD];
        sel_wr           = s_axis_tdata_write_dependencies[i*MD +: MD];
      end
    end
  end

  // Next-state logic
  always_comb begin
    tvalid_d     = tvalid_q;
    prog_d       = prog_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    tsource_d    = tsource_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    grants_d     = grants_q;
    contend_d    = contend_q;

    if (handshake) begin
      tvalid_d     = 1'b1;
      prog_d       = sel_prog;
      rd_d         = sel_rd;
      wr_d         = sel_wr;
      tsource_d    = grant;
      last_grant_d = grant;
      if (grant != last_grant_q) begin
        burst_cnt_d = BC_W'(1);
      end else if (burst_cnt_q < BURST_LIMIT) begin
        burst_cnt_d = burst_cnt_q + BC_W'(1);
      end
      if (grants_q != '1) begin
        grants_d = grants_q + 32'd1;
      end
    end else if (tvalid_q && m_axis_tready) begin
      // Drain without refill; data registers keep their last value.
      tvalid_d = 1'b0;
    end

    if (!pause && multi_valid && (contend_q != '1)) begin
      contend_d = contend_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tvalid_q     <= 1'b0;
      prog_q       <= '0;
      rd_q         <= '0;
      wr_q         <= '0;
      tsource_q    <= '0;
      last_grant_q <= LAST_SRC;
      burst_cnt_q  <= '0;
      grants_q     <= '0;
      contend_q    <= '0;
    end else begin
      tvalid_q     <= tvalid_d;
      prog_q       <= prog_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      tsource_q    <= tsource_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      grants_q     <= grants_d;
      contend_q    <= contend_d;
    end
  end

  assign m_axis_tvalid                   = tvalid_q;
  assign m_axis_tdata_owner_programID    = prog_q;
  assign m_axis_tdata_read_dependencies  = rd_q;
  assign m_axis_tdata_write_dependencies = wr_q;
  assign m_axis_tsource                  = tsource_q;
  assign grants_total                    = grants_q;
  assign contention_cycles               = contend_q;

endmodule
`default_nettype wire

// File: tb/tb_ingress_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ingress_arbiter
// Purpose  : Self-checking bench for ingress_arbiter. Sources hold each beat
//            until accepted; a reference model predicts grants, counters and
//            slot occupancy and queues expected output beats for a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ingress_arbiter;

  localparam int N  = 4;
  localparam int MD = 32;
  localparam int MB = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     s_tvalid;
  logic [N-1:0]     s_tready;
  logic [N*64-1:0]  s_prog;
  logic [N*MD-1:0]  s_rd;
  logic [N*MD-1:0]  s_wr;
  logic             pause;
  logic             m_tvalid;
  logic             m_tready;
  logic [63:0]      m_prog;
  logic [MD-1:0]    m_rd;
  logic [MD-1:0]    m_wr;
  logic [1:0]       m_src;
  logic [31:0]      gt;
  logic [31:0]      cc;

  ingress_arbiter #(
    .NUM_REQUESTERS  (N),
    .MAX_DEPENDENCIES(MD),
    .MAX_BURST       (MB)
  ) dut (
    .clk                            (clk),
    .rst                            (rst),
    .s_axis_tvalid                  (s_tvalid),
    .s_axis_tready                  (s_tready),
    .s_axis_tdata_owner_programID   (s_prog),
    .s_axis_tdata_read_dependencies (s_rd),
    .s_axis_tdata_write_dependencies(s_wr),
    .pause                          (pause),
    .m_axis_tvalid                  (m_tvalid),
    .m_axis_tready                  (m_tready),
    .m_axis_tdata_owner_programID   (m_prog),
    .m_axis_tdata_read_dependencies (m_rd),
    .m_axis_tdata_write_dependencies(m_wr),
    .m_axis_tsource                 (m_src),
    .grants_total                   (gt),
    .contention_cycles              (cc)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Source-side held beats
  logic [N-1:0]  hold;
  logic [N-1:0]  acc_prev;
  logic [63:0]   h_prog [N];
  logic [MD-1:0] h_rd   [N];
  logic [MD-1:0] h_wr   [N];

  // Reference model state
  int            last;
  int            burst;
  bit            slot_full;
  logic [31:0]   m_gt;
  logic [31:0]   m_cc;
  logic [129:0]  exp_q [$];

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Who should win, from the arbitration rules
  function automatic int pick(input logic [N-1:0] v);
    if (burst > 0 && burst < MB && v[last]) return last;
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    last      = N - 1;
    burst     = 0;
    slot_full = 1'b0;
    m_gt      = '0;
    m_cc      = '0;
    acc_prev  = '0;
    exp_q.delete();
  endtask

  // Runs once per cycle after inputs settle, before the rising edge.
  task automatic model_step();
    logic [N-1:0] v;
    logic [N-1:0] exp_rdy;
    bit           le;
    int           g;
    v = s_tvalid;
    g = -1;
    chk("m_tvalid", m_tvalid, slot_full);
    chk("grants_total", gt, m_gt);
    chk("contention_cycles", cc, m_cc);
    le = !pause && (!slot_full || m_tready);
    if (le && v != '0) g = pick(v);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("s_tready", s_tready, exp_rdy);
    acc_prev = s_tready & v;
    if (g >= 0) begin
      exp_q.push_back({2'(g), h_prog[g], h_rd[g], h_wr[g]});
      if (m_gt != 32'hFFFF_FFFF) m_gt = m_gt + 1;
      burst = (burst > 0 && g == last) ? ((burst < MB) ? burst + 1 : MB) : 1;
      last  = g;
    end
    if (!pause && $countones(v) >= 2 && m_cc != 32'hFFFF_FFFF) m_cc = m_cc + 1;
    if (g >= 0)                      slot_full = 1'b1;
    else if (slot_full && m_tready)  slot_full = 1'b0;
  endtask

  task automatic step(input logic [N-1:0] want, input bit p, input bit rdy);
    @(negedge clk);
    hold = hold & ~acc_prev;
    for (int i = 0; i < N; i++) begin
      if (!hold[i] && want[i]) begin
        hold[i]   = 1'b1;
        h_prog[i] = {$urandom, $urandom};
        h_rd[i]   = $urandom;
        h_wr[i]   = $urandom;
      end
      s_prog[i*64 +: 64] = h_prog[i];
      s_rd[i*MD +: MD]   = h_rd[i];
      s_wr[i*MD +: MD]   = h_wr[i];
    end
    s_tvalid = hold;
    pause    = p;
    m_tready = rdy;
    #1;
    model_step();
  endtask

  // Called right after a step: asserts reset between edges.
  task automatic do_reset();
    #2;
    rst      = 1'b1;
    s_tvalid = '0;
    hold     = '0;
    #1;
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_s_tready", s_tready, '0);
    chk("rst_m_tsource", m_src, 2'd0);
    chk("rst_m_prog", m_prog, 64'd0);
    chk("rst_grants", gt, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: compares the beat in the slot whenever it is about to drain.
  initial begin
    logic [129:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst === 1'b0 && m_tvalid === 1'b1 && m_tready === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {m_src, m_prog, m_rd, m_wr}, '0);
        end else begin
          e = exp_q.pop_front();
          chk("beat", {m_src, m_prog, m_rd, m_wr}, e);
        end
      end
    end
  end

  initial begin
    rst      = 1'b1;
    s_tvalid = '0;
    s_prog   = '0;
    s_rd     = '0;
    s_wr     = '0;
    pause    = 1'b0;
    m_tready = 1'b0;
    hold     = '0;
    for (int i = 0; i < N; i++) begin
      h_prog[i] = '0;
      h_rd[i]   = '0;
      h_wr[i]   = '0;
    end
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("init_m_tvalid", m_tvalid, 1'b0);
    chk("init_s_tready", s_tready, '0);
    chk("init_contention", cc, 32'd0);
    rst = 1'b0;

    // Single source streaming back-to-back
    repeat (5) step(4'b0100, 1'b0, 1'b1);
    repeat (3) step(4'b0000, 1'b0, 1'b1);
    chk("single_src_grants", gt, 32'd5);

    // All sources valid: bursts of MB per source in rotation
    repeat (20) step(4'b1111, 1'b0, 1'b1);
    repeat (6)  step(4'b0000, 1'b0, 1'b1);

    // Downstream stall with two contenders
    step(4'b1010, 1'b0, 1'b1);
    repeat (10) step(4'b1010, 1'b0, 1'b0);
    repeat (6)  step(4'b0000, 1'b0, 1'b1);

    // Pause with a full slot, then release
    step(4'b0011, 1'b0, 1'b0);
    repeat (2) step(4'b0011, 1'b1, 1'b0);
    repeat (3) step(4'b0011, 1'b1, 1'b1);
    repeat (4) step(4'b0011, 1'b0, 1'b1);
    repeat (4) step(4'b0000, 1'b0, 1'b1);

    // Reset mid-stream with the slot full
    repeat (3) step(4'b1111, 1'b0, 1'b1);
    do_reset();
    repeat (2) step(4'b0110, 1'b0, 1'b1);
    repeat (4) step(4'b0000, 1'b0, 1'b1);

    // Saturation of grants_total
    step(4'b0000, 1'b0, 1'b1);
    #2;
    force dut.grants_q = 32'hFFFF_FFFE;
    #1;
    release dut.grants_q;
    m_gt = 32'hFFFF_FFFE;
    repeat (3) step(4'b0001, 1'b0, 1'b1);
    repeat (2) step(4'b0000, 1'b0, 1'b1);
    chk("grants_saturated", gt, 32'hFFFF_FFFF);

    // Randomized traffic
    repeat (3000) step(4'($urandom), ($urandom % 8) == 0, ($urandom % 4) != 0);
    repeat (12) step(4'b0000, 1'b0, 1'b1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
